// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the memory-stall timeout.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alucont,
  output logic       nez,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BREX   = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11
  } state_e;

  typedef struct packed {
    logic [2:0] alucont;
    logic       nez;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       regwrite;
  } ctrl_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q;
  logic          wait_st;
  logic          stall;
  logic          tmo_hit;
  logic          pcwrite;

  function automatic logic rt_legal(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic op_legal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: return 1'b1;
      OP_RTYPE: return rt_legal(f);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] rt_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Moore decode of a state; op/funct are stable for the whole instruction
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] o,
                                        input logic [5:0] f);
    ctrl_t c;
    c         = '0;
    c.alucont = ALU_ADD;
    case (st)
      S_FETCH:  c.alusrcb = SRCB_FOUR;
      S_DECODE: c.alusrcb = SRCB_IMM2;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMRD:  c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR:  c.iord = 1'b1;
      S_RTEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.alucont = rt_alu(f);
      end
      S_RTWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.alucont  = rt_alu(f);
      end
      S_BREX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.alucont = ALU_SUB;
        c.pcsrc   = PCSRC_OUT;
        c.nez     = (o == OP_BNE);
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JEX:    c.pcsrc = PCSRC_JUMP;
      default:  c.pcsrc = PCSRC_ALU;
    endcase
    return c;
  endfunction

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);
  assign stall   = wait_st && !mem_ready;
  assign tmo_hit = (TIMEOUT != 0) && stall && (cnt_q == CW'(TMO_LAST));

  // Next-state and stall-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = rt_legal(funct) ? S_RTEX : S_FETCH;
          OP_BEQ, OP_BNE:  state_d = S_BREX;
          OP_ADDI:         state_d = S_ADDIEX;
          OP_J:            state_d = S_JEX;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (tmo_hit) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || tmo_hit) state_d = S_FETCH;
      end
      S_RTEX:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    if ((TIMEOUT != 0) && stall && !tmo_hit && (state_d == state_q))
      cnt_d = cnt_q + CW'(1);
  end

  // State register with Moore control fields registered from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ctrl_q  <= decode_ctrl(S_FETCH, op, funct);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode_ctrl(state_d, op, funct);
    end
  end

  assign alucont  = ctrl_q.alucont;
  assign nez      = ctrl_q.nez;
  assign iord     = ctrl_q.iord;
  assign memtoreg = ctrl_q.memtoreg;
  assign regdst   = ctrl_q.regdst;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign state_o  = state_q;

  // Input-qualified strobes, all forced low while reset is held
  assign pcwrite     = ((state_q == S_FETCH) && mem_ready) || (state_q == S_JEX);
  assign pcen        = reset_n && (pcwrite || ((state_q == S_BREX) && zero));
  assign irwrite     = reset_n && (state_q == S_FETCH) && mem_ready;
  assign memwrite    = reset_n && (state_q == S_MEMWR) && !tmo_hit;
  assign regwrite    = reset_n && ctrl_q.regwrite;
  assign illegal     = reset_n && (state_q == S_DECODE) && !op_legal(op, funct);
  assign mem_timeout = reset_n && tmo_hit;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequences, stalls, timeout
// and mid-instruction reset, with hand-computed expectations.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic [2:0] alucont;
  logic       nez, memwrite, irwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       illegal, mem_timeout;
  logic [3:0] state_o;

  logic [2:0] z_alucont;
  logic       z_nez, z_memwrite, z_irwrite, z_regwrite, z_pcen, z_iord, z_memtoreg;
  logic       z_regdst, z_alusrca;
  logic [1:0] z_alusrcb, z_pcsrc;
  logic       z_illegal, z_mem_timeout;
  logic [3:0] z_state_o;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alucont(alucont), .nez(nez), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .pcen(pcen), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .illegal(illegal), .mem_timeout(mem_timeout), .state_o(state_o)
  );

  multicycle_ctrl #(.TIMEOUT(0)) dut_notmo (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alucont(z_alucont), .nez(z_nez), .memwrite(z_memwrite),
    .irwrite(z_irwrite), .regwrite(z_regwrite), .pcen(z_pcen), .iord(z_iord),
    .memtoreg(z_memtoreg), .regdst(z_regdst), .alusrca(z_alusrca),
    .alusrcb(z_alusrcb), .pcsrc(z_pcsrc), .illegal(z_illegal),
    .mem_timeout(z_mem_timeout), .state_o(z_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [5:0] o, input logic z, input logic exp_pcen,
                        input logic exp_nez);
    op = o; mem_ready = 1'b1;
    tick(); tick();
    zero = z; #1;
    check("br_state", 32'(state_o), 32'd8);
    check("br_pcen", 32'(pcen), 32'(exp_pcen));
    check("br_pcsrc", 32'(pcsrc), 32'd1);
    check("br_nez", 32'(nez), 32'(exp_nez));
    check("br_alucont", 32'(alucont), 32'd6);
    tick();
    zero = 1'b0; #1;
    check("br_done", 32'(state_o), 32'd0);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [2:0] exp_alu);
    op = OP_RTYPE; funct = f; mem_ready = 1'b1;
    tick(); tick(); #1;
    check("rt_ex_state", 32'(state_o), 32'd6);
    check("rt_ex_alucont", 32'(alucont), 32'(exp_alu));
    check("rt_ex_srcab", 32'({alusrca, alusrcb}), 32'b100);
    check("rt_ex_regwrite", 32'(regwrite), 32'd0);
    tick(); #1;
    check("rt_wb_state", 32'(state_o), 32'd7);
    check("rt_wb_alucont", 32'(alucont), 32'(exp_alu));
    check("rt_wb_regdst", 32'(regdst), 32'd1);
    check("rt_wb_regwrite", 32'(regwrite), 32'd1);
    tick(); #1;
    check("rt_done", 32'(state_o), 32'd0);
  endtask

  task automatic bad_instr(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f; mem_ready = 1'b1;
    tick(); #1;
    check("ill_state", 32'(state_o), 32'd1);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_regwrite", 32'(regwrite), 32'd0);
    tick(); #1;
    check("ill_next", 32'(state_o), 32'd0);
    check("ill_clear", 32'(illegal), 32'd0);
    check("ill_regwrite2", 32'(regwrite), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr_cnt;
    int held;
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1; #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_pcen", 32'(pcen), 32'd0);
    mem_ready = 1'b0; reset_n = 1'b1;
    tick();
    check("rel_state", 32'(state_o), 32'd0);

    // lw with no wait states
    op = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("lw_state", 32'(state_o), 32'(i));
      check("lw_regwrite", 32'(regwrite), 32'(i == 4));
      check("lw_memtoreg", 32'(memtoreg), 32'(i == 4));
      check("lw_pcen", 32'(pcen), 32'(i == 0));
      tick();
    end
    check("lw_done", 32'(state_o), 32'd0);

    // sw with three wait cycles in MEMWR
    op = OP_SW; mem_ready = 1'b1;
    tick(); tick(); tick();
    wr_cnt = 0; held = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      if (memwrite) wr_cnt++;
      if (state_o == 4'd5) held++;
      check("sw_iord", 32'(iord), 32'd1);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("sw_memwrite_cycles", 32'(wr_cnt), 32'd4);
    check("sw_state_held", 32'(held), 32'd4);
    check("sw_done", 32'(state_o), 32'd0);
    check("sw_memwrite_off", 32'(memwrite), 32'd0);

    branch(OP_BEQ, 1'b1, 1'b1, 1'b0);
    branch(OP_BNE, 1'b0, 1'b0, 1'b1);
    branch(OP_BEQ, 1'b0, 1'b0, 1'b0);
    branch(OP_BNE, 1'b1, 1'b1, 1'b1);

    rtype(6'b101010, 3'b111);
    rtype(6'b100010, 3'b110);
    rtype(6'b100100, 3'b000);
    rtype(6'b100101, 3'b001);

    bad_instr(OP_RTYPE, 6'b000000);
    bad_instr(6'b111111, 6'b100000);

    // jump
    op = OP_J; mem_ready = 1'b1;
    tick(); tick(); #1;
    check("j_state", 32'(state_o), 32'd11);
    check("j_pcen", 32'(pcen), 32'd1);
    check("j_pcsrc", 32'(pcsrc), 32'd2);
    tick(); #1;
    check("j_done", 32'(state_o), 32'd0);

    // addi
    op = OP_ADDI;
    tick(); tick(); #1;
    check("addi_ex_state", 32'(state_o), 32'd9);
    check("addi_ex_srcab", 32'({alusrca, alusrcb}), 32'b110);
    tick(); #1;
    check("addi_wb_state", 32'(state_o), 32'd10);
    check("addi_wb_ctl", 32'({regwrite, regdst, memtoreg}), 32'b100);
    tick(); #1;
    check("addi_done", 32'(state_o), 32'd0);

    // lw stalled in MEMRD until the limit of 4 cycles
    op = OP_LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("tmo_state", 32'(state_o), 32'd3);
      check("tmo_pulse", 32'(mem_timeout), 32'(k == 4));
      check("tmo_off_pulse", 32'(z_mem_timeout), 32'd0);
      check("tmo_regwrite", 32'(regwrite), 32'd0);
      tick();
    end
    #1;
    check("tmo_next", 32'(state_o), 32'd0);
    check("tmo_off_state", 32'(z_state_o), 32'd3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; #1;
    check("resync_state", 32'(z_state_o), 32'd0);

    // reset during RTEX aborts the add
    op = OP_RTYPE; funct = 6'b100000; mem_ready = 1'b1;
    tick(); tick(); #1;
    check("abort_rtex", 32'(state_o), 32'd6);
    reset_n = 1'b0; #1;
    check("abort_regwrite", 32'(regwrite), 32'd0);
    tick();
    reset_n = 1'b1; #1;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_regwrite2", 32'(regwrite), 32'd0);
    check("refetch_pcen", 32'(pcen), 32'd1);
    check("refetch_irwrite", 32'(irwrite), 32'd1);
    tick(); tick(); tick(); #1;
    check("refetch_rtwb", 32'(state_o), 32'd7);
    check("refetch_regwrite", 32'(regwrite), 32'd1);
    check("refetch_alucont", 32'(alucont), 32'd2);
    tick(); #1;
    check("refetch_done", 32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath multiplexer selects and write enables. It issues the `alucont`/`nez` command to the ALU and consumes the ALU `zero` flag to resolve `beq`/`bne`. It also stalls on a memory ready handshake, with an optional stall timeout.

## Interface
Parameters:
- `TIMEOUT`, default 0: maximum number of stall cycles per memory state. 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state changes occur on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `op`  in  6  instruction bits [31:26], taken from the instruction register.
- `funct`  in  6  instruction bits [5:0].
- `zero`  in  1  ALU flag; already inverted by the ALU when `nez`=1.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `alucont`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `nez`  out  1  branch-on-not-equal select, sent to the ALU.
- `memwrite`, `irwrite`, `regwrite`  out  1 each  write enables.
- `pcen`  out  1  PC write enable; equals pcwrite | (branch & zero).
- `iord`, `memtoreg`, `regdst`, `alusrca`  out  1 each  datapath selects.
- `alusrcb`  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `pcsrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `illegal`  out  1  one-cycle pulse on an unsupported op or funct.
- `mem_timeout`  out  1  one-cycle pulse when the stall limit is hit.
- `state_o`  out  4  current state encoding, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BREX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- Every output not listed for a state is 0. `alucont` defaults to 010 unless listed.
- FETCH: iord=0, alusrca=0, alusrcb=01, alucont=010, pcsrc=00.
  - irwrite and pcwrite are asserted only while mem_ready=1.
  - Moves to DECODE when mem_ready=1; otherwise stays in FETCH.
- DECODE: alusrca=0, alusrcb=11, alucont=010 (computes the branch target). Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → RTEX, if funct ∈ {100000, 100010, 100100, 100101, 101010}.
  - 000100 (beq) or 000101 (bne) → BREX.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JEX.
  - Any other op, or R-type with any other funct → FETCH, with `illegal` asserted for this cycle.
- MEMADR: alusrca=1, alusrcb=10, alucont=010. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1; waits for mem_ready, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1. memwrite is held until the cycle mem_ready=1, then → FETCH.
- RTEX: alusrca=1, alusrcb=00. alucont by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Then → RTWB.
- RTWB: regdst=1, memtoreg=0, regwrite=1, with the same alucont as RTEX → FETCH.
- BREX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01, branch=1 → FETCH.
  - nez=0 for op 000100 (beq), nez=1 for op 000101 (bne).
  - pcen = zero.
- ADDIEX: alusrca=1, alusrcb=10, alucont=010 → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
- JEX: pcsrc=10, pcwrite=1 → FETCH.
- Stall counter (only when TIMEOUT>0):
  - Counts consecutive cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change.
  - When the count reaches TIMEOUT: `mem_timeout` pulses, no write enable is asserted, and the next state is FETCH.
  - If mem_ready=1 in that same cycle, mem_ready takes priority and no timeout occurs.

## Timing
- Reset: while reset_n=0, every write enable (irwrite, pcen, memwrite, regwrite), `illegal` and `mem_timeout` is combinationally forced to 0.
- The first rising edge with reset_n=0 loads state=FETCH and clears the stall counter. After release, state_o=0.
- Reset asserted mid-instruction aborts the instruction at the next edge with no further writes.
- All outputs are decoded from the state register, except:
  - `pcen`, which depends on `zero` in BREX;
  - irwrite, pcwrite and memwrite, which are qualified by `mem_ready` as described in Operation;
  - `illegal` and `mem_timeout`, which depend on the current inputs.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each wait cycle adds 1.
- `op` and `funct` are required stable from the FETCH exit edge until the instruction returns to FETCH.

## Test plan
- lw, mem_ready tied to 1: state_o sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. pcen=1 only in state 0.
- sw, mem_ready low for 3 cycles in MEMWR: memwrite high for 4 cycles, state 5 held for 4 cycles, then 0.
- beq with zero=1 in BREX: pcen=1, pcsrc=01, nez=0. Repeat with bne and zero=0: pcen=0, nez=1.
- R-type funct=101010: alucont=111 in states 6 and 7, regdst=1. funct=000000: `illegal` pulses in DECODE, next state 0, regwrite never asserted.
- TIMEOUT=4, mem_ready held 0 in MEMRD: `mem_timeout` pulses on the 4th stall cycle, next state 0.
- reset_n=0 for one cycle during RTEX: no regwrite occurs, state_o=0 after the edge, and the next fetch proceeds normally.
